// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared controller codes, FSM states and owner encoding for mem_arbiter.
package mem_arbiter_pkg;
   localparam logic [15:0] UART_ADDR            = 16'hBF00;
   localparam logic [7:0]  RAM1_READ1           = 8'h51;
   localparam logic [7:0]  RAM1_WRITE1          = 8'h61;
   localparam logic [7:0]  UART_WRITE1          = 8'hE1;
   localparam logic [7:0]  UART_READ_FROM_QUEUE = 8'h83;
   localparam logic [7:0]  CTRL_IDLE            = 8'h00;
   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_DONE = 2'd2,
      S_RESP      = 2'd3
   } state_t;
   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_t;
   function automatic logic is_start(input logic [7:0] s);
      return s == RAM1_READ1 || s == RAM1_WRITE1 || s == UART_WRITE1 || s == UART_READ_FROM_QUEUE;
   endfunction
endpackage

// File: rtl/mem_arbiter_fetch_buf.sv
// fetch_buf: one-entry instruction buffer (valid, tag, data) with lookup, fill and invalidate.
module fetch_buf #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              hit,
   output logic [DATA_W-1:0] hit_data,
   input  logic              fill_en,
   input  logic [ADDR_W-1:0] fill_addr,
   input  logic [DATA_W-1:0] fill_data,
   input  logic              inval
);
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] tag_q, tag_d;
   logic [DATA_W-1:0] data_q, data_d;
   always_comb begin
      valid_d = inval ? 1'b0 : (fill_en ? 1'b1 : valid_q);
      tag_d   = fill_en ? fill_addr : tag_q;
      data_d  = fill_en ? fill_data : data_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
      end
   end
   assign hit      = valid_q && tag_q == lookup_addr;
   assign hit_data = data_q;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IF and MEM accesses onto the RAM1/UART controller command port.
// Defining MEM_ARB_IBUF_EN adds a one-entry fetch buffer that answers repeat fetches locally.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_data,
   output logic              if_ready,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr_in,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              busy,
   output logic              need_to_work,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_value,
   input  logic              uart_work_done,
   input  logic [DATA_W-1:0] result,
   input  logic [7:0]        ram_status
);
   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic              need_to_work_q, need_to_work_d;
   logic              mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_value_q, mem_value_d;
   logic [DATA_W-1:0] if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
   logic              if_ready_q, if_ready_d, mem_ready_q, mem_ready_d;
   logic              busy_q, busy_d;
   logic              done;
   logic              ibuf_hit;
   logic [DATA_W-1:0] ibuf_data;
   assign done = ram_status == CTRL_IDLE && uart_work_done;
`ifdef MEM_ARB_IBUF_EN
   logic ibuf_fill, ibuf_inval;
   assign ibuf_inval = state_q == S_IDLE && mem_req && mem_we;
   assign ibuf_fill  = state_q == S_WAIT_DONE && done && owner_q == OWN_IF && mem_addr_q != ADDR_W'(UART_ADDR);
   fetch_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fetch_buf (
      .clk         (clk),
      .rst         (rst),
      .lookup_addr (if_addr),
      .hit         (ibuf_hit),
      .hit_data    (ibuf_data),
      .fill_en     (ibuf_fill),
      .fill_addr   (mem_addr_q),
      .fill_data   (result),
      .inval       (ibuf_inval)
   );
`else
   assign ibuf_hit  = 1'b0;
   assign ibuf_data = '0;
`endif
   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      need_to_work_d = need_to_work_q;
      mem_rd_d       = mem_rd_q;
      mem_wr_d       = mem_wr_q;
      mem_addr_d     = mem_addr_q;
      mem_value_d    = mem_value_q;
      if_data_d      = if_data_q;
      mem_rdata_d    = mem_rdata_q;
      if_ready_d     = 1'b0;
      mem_ready_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mem_req) begin
               state_d        = S_ISSUE;
               owner_d        = OWN_MEM;
               need_to_work_d = 1'b1;
               mem_rd_d       = ~mem_we;
               mem_wr_d       = mem_we;
               mem_addr_d     = mem_addr_in;
               mem_value_d    = mem_wdata;
            end else if (if_req && ibuf_hit) begin
               state_d    = S_RESP;
               owner_d    = OWN_IF;
               if_data_d  = ibuf_data;
               if_ready_d = 1'b1;
            end else if (if_req) begin
               state_d        = S_ISSUE;
               owner_d        = OWN_IF;
               need_to_work_d = 1'b1;
               mem_rd_d       = 1'b1;
               mem_wr_d       = 1'b0;
               mem_addr_d     = if_addr;
               mem_value_d    = '0;
            end
         end
         // Non-start codes (e.g. a UART receive pre-empting us) just keep us waiting.
         S_ISSUE: begin
            if (is_start(ram_status)) begin
               state_d        = S_WAIT_DONE;
               need_to_work_d = 1'b0;
            end
         end
         S_WAIT_DONE: begin
            if (done) begin
               state_d     = S_RESP;
               mem_ready_d = owner_q == OWN_MEM;
               if_ready_d  = owner_q == OWN_IF;
               mem_rdata_d = (owner_q == OWN_MEM && mem_rd_q) ? result : mem_rdata_q;
               if_data_d   = owner_q == OWN_IF ? result : if_data_q;
            end
         end
         default: begin
            state_d  = S_IDLE;
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
         end
      endcase
   end
   assign busy_d = state_d != S_IDLE;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         owner_q        <= OWN_IF;
         need_to_work_q <= 1'b0;
         mem_rd_q       <= 1'b0;
         mem_wr_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_value_q    <= '0;
         if_data_q      <= '0;
         mem_rdata_q    <= '0;
         if_ready_q     <= 1'b0;
         mem_ready_q    <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         need_to_work_q <= need_to_work_d;
         mem_rd_q       <= mem_rd_d;
         mem_wr_q       <= mem_wr_d;
         mem_addr_q     <= mem_addr_d;
         mem_value_q    <= mem_value_d;
         if_data_q      <= if_data_d;
         mem_rdata_q    <= mem_rdata_d;
         if_ready_q     <= if_ready_d;
         mem_ready_q    <= mem_ready_d;
         busy_q         <= busy_d;
      end
   end
   assign need_to_work = need_to_work_q;
   assign mem_rd       = mem_rd_q;
   assign mem_wr       = mem_wr_q;
   assign mem_addr     = mem_addr_q;
   assign mem_value    = mem_value_q;
   assign if_data      = if_data_q;
   assign mem_rdata    = mem_rdata_q;
   assign if_ready     = if_ready_q;
   assign mem_ready    = mem_ready_q;
   assign busy         = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural RAM1/UART controller.
// Fetch-buffer checks are compiled only when MEM_ARB_IBUF_EN is defined.
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
   logic [15:0] if_addr = '0, mem_addr_in = '0, mem_wdata = '0;
   logic [15:0] if_data, mem_rdata, mem_addr, mem_value, result;
   logic        if_ready, mem_ready, busy, need_to_work, mem_rd, mem_wr, uart_work_done;
   logic [7:0]  ram_status;
   int          checks = 0, errors = 0, cmd_cnt = 0;
   typedef struct {
      bit          is_mem;
      bit          chk_data;
      logic [15:0] data;
   } exp_t;
   exp_t        sb[$];
   logic [15:0] mdl[logic [15:0]];

   mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_ready(if_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_in(mem_addr_in), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy),
      .need_to_work(need_to_work), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_value(mem_value),
      .uart_work_done(uart_work_done), .result(result), .ram_status(ram_status)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Controller model: UART reads run three receive codes before the queue start code.
   initial begin
      logic [15:0] ca, cv;
      logic        crd;
      ram_status = 8'h00;
      uart_work_done = 1'b1;
      result = '0;
      forever begin
         @(negedge clk);
         if (need_to_work) begin
            cmd_cnt++;
            ca = mem_addr;
            cv = mem_value;
            crd = mem_rd;
            @(posedge clk); #1 uart_work_done = 1'b0;
            if (crd && ca == 16'hBF00)
               for (int i = 0; i < 3; i++) begin
                  ram_status = 8'h80 + i[7:0];
                  @(posedge clk); #1;
               end
            ram_status = crd ? (ca == 16'hBF00 ? 8'h83 : 8'h51) : (ca == 16'hBF00 ? 8'hE1 : 8'h61);
            @(posedge clk); #1 ram_status = 8'h52;
            @(posedge clk); #1 ram_status = 8'h53;
            @(posedge clk); #1;
            if (crd) result = mdl.exists(ca) ? mdl[ca] : 16'h0000;
            else mdl[ca] = cv;
            ram_status = 8'h00;
            uart_work_done = 1'b1;
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (if_ready || mem_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_ready: if_ready %b mem_ready %b with nothing outstanding", if_ready, mem_ready);
            end else begin
               e = sb.pop_front();
               if (!(if_ready ^ mem_ready) || mem_ready != e.is_mem ||
                   (e.chk_data && (e.is_mem ? mem_rdata : if_data) !== e.data)) begin
                  errors++;
                  $display("FAIL ready_resp: got if_ready %b mem_ready %b if_data %h mem_rdata %h expected is_mem %b data %h",
                           if_ready, mem_ready, if_data, mem_rdata, e.is_mem, e.data);
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic if_go(input logic [15:0] a, output int cyc);
      if_req = 1'b1;
      if_addr = a;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!if_ready && cyc < 200);
      if (!if_ready) chk("if_timeout", 64'(cyc), 64'd0);
      @(posedge clk); #1 if_req = 1'b0;
   endtask

   task automatic mem_go(input logic we, input logic [15:0] a, input logic [15:0] d, output int cyc);
      mem_req = 1'b1;
      mem_we = we;
      mem_addr_in = a;
      mem_wdata = d;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!mem_ready && cyc < 200);
      if (!mem_ready) chk("mem_timeout", 64'(cyc), 64'd0);
      @(posedge clk); #1 mem_req = 1'b0;
   endtask

   task automatic watch_need(output logic [7:0] last, output logic [15:0] a, output logic [15:0] v,
                             output logic rd, output logic wr);
      int n;
      n = 0;
      last = 8'hxx;
      do begin
         @(negedge clk);
         n++;
      end while (!need_to_work && n < 200);
      a = mem_addr;
      v = mem_value;
      rd = mem_rd;
      wr = mem_wr;
      while (need_to_work && n < 400) begin
         last = ram_status;
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int          c1, c2, n, n0;
      logic [7:0]  last;
      logic [15:0] wa, wv;
      logic        wrd, wwr;
      mdl[16'h0010] = 16'h1234;
      mdl[16'h0030] = 16'h3030;
      mdl[16'h0050] = 16'h5050;
      mdl[16'hBF00] = 16'h00A5;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctrl", {need_to_work, mem_rd, mem_wr, busy, if_ready, mem_ready}, 64'd0);
      chk("rst_regs", {mem_addr, mem_value, if_data, mem_rdata}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_after_rst", {need_to_work, busy}, 64'd0);

      sb.push_back('{1'b0, 1'b1, 16'h1234});
      fork
         if_go(16'h0010, c1);
         watch_need(last, wa, wv, wrd, wwr);
      join
      chk("if_cmd", {wa, wrd, wwr}, {16'h0010, 1'b1, 1'b0});
      chk("if_need_until_51", last, 8'h51);

      sb.push_back('{1'b1, 1'b0, 16'h0000});
      sb.push_back('{1'b0, 1'b1, 16'h1234});
      fork
         mem_go(1'b1, 16'h0020, 16'hBEEF, c1);
         if_go(16'h0010, c2);
         watch_need(last, wa, wv, wrd, wwr);
      join
      chk("store_cmd", {wa, wv, wrd, wwr}, {16'h0020, 16'hBEEF, 1'b0, 1'b1});
      chk("store_start_code", last, 8'h61);
      chk("store_written", mdl[16'h0020], 16'hBEEF);
      chk("mem_before_if", 64'(c1 < c2), 64'd1);

      sb.push_back('{1'b1, 1'b1, 16'hBEEF});
      mem_go(1'b0, 16'h0020, 16'h0000, c1);

      sb.push_back('{1'b1, 1'b1, 16'h00A5});
      fork
         mem_go(1'b0, 16'hBF00, 16'h0000, c1);
         watch_need(last, wa, wv, wrd, wwr);
         begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (ram_status != 8'h82 && n < 200);
            chk("issue_through_rx", {need_to_work, busy}, 64'b11);
         end
      join
      chk("uart_start_code", last, 8'h83);
      chk("uart_cmd", {wa, wrd}, {16'hBF00, 1'b1});

      @(posedge clk); #1;
      if_req = 1'b1;
      if_addr = 16'h0050;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!need_to_work && n < 200);
      while (need_to_work && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("reached_wait_done", 64'(n < 400), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("midop_rst_ctrl", {need_to_work, mem_rd, mem_wr, busy, if_ready, mem_ready}, 64'd0);
      chk("midop_rst_regs", {mem_addr, mem_value, if_data, mem_rdata}, 64'd0);
      if_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("no_pending_after_rst", 64'(sb.size()), 64'd0);
      sb.push_back('{1'b0, 1'b1, 16'h5050});
      if_go(16'h0050, c1);

`ifdef MEM_ARB_IBUF_EN
      sb.push_back('{1'b0, 1'b1, 16'h3030});
      if_go(16'h0030, c1);
      n0 = cmd_cnt;
      sb.push_back('{1'b0, 1'b1, 16'h3030});
      if_go(16'h0030, c1);
      chk("hit_latency", 64'(c1), 64'd2);
      chk("hit_no_ctrl", 64'(cmd_cnt), 64'(n0));
      sb.push_back('{1'b1, 1'b0, 16'h0000});
      mem_go(1'b1, 16'h0040, 16'h4444, c1);
      n0 = cmd_cnt;
      sb.push_back('{1'b0, 1'b1, 16'h3030});
      if_go(16'h0030, c1);
      chk("miss_after_store", 64'(cmd_cnt), 64'(n0 + 1));
`else
      n0 = cmd_cnt;
      sb.push_back('{1'b0, 1'b1, 16'h5050});
      if_go(16'h0050, c1);
      chk("refetch_uses_ctrl", 64'(cmd_cnt), 64'(n0 + 1));
`endif
      repeat (5) @(posedge clk);
      #1;
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between instruction fetch (IF) and the memory stage (MEM) of the pipeline. It serialises both requesters onto the one command port of the RAM1/UART controller and sequences each access through that controller's start/finish handshake. It returns read data and a one-cycle ready pulse per requester, which the pipeline uses for stall control.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous and active-high; the top level inverts the controller's active-low reset from the same source
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_data  out  DATA_W  fetched word, valid with if_ready
- if_ready  out  1  one-cycle completion pulse
- mem_req  in  1  load/store request, held until mem_ready
- mem_we  in  1  1 = store, 0 = load
- mem_addr_in  in  ADDR_W  load/store address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data, valid with mem_ready
- mem_ready  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE
- need_to_work  out  1  command strobe to the controller
- mem_rd / mem_wr  out  1 each  command type to the controller
- mem_addr  out  ADDR_W  command address
- mem_value  out  DATA_W  command write data
- uart_work_done  in  1  controller done level
- result  in  DATA_W  controller read data
- ram_status  in  8  controller state code

## Operation
- FSM: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE:
  - If mem_req, grant MEM. Otherwise, if if_req, grant IF.
  - On grant, latch owner, address, data and type into the command registers, then go to ISSUE.
  - Fixed priority: MEM wins on simultaneous requests. IF waits and is not dropped.
- ISSUE:
  - need_to_work=1. mem_rd = ~we and mem_wr = we; IF is always a read.
  - Wait until ram_status equals a start code: RAM1_READ1 8'h51, RAM1_WRITE1 8'h61, UART_WRITE1 8'hE1, UART_READ_FROM_QUEUE 8'h83.
  - On a start code, drop need_to_work and go to WAIT_DONE.
  - Any other code is ignored and ISSUE keeps waiting. This covers a UART-receive sequence that pre-empts the command.
- WAIT_DONE: wait for ram_status==8'h00 and uart_work_done==1 in the same cycle. Then latch result into the owner's data register (reads only) and go to RESP.
- RESP:
  - Pulse the owner's ready for exactly one cycle, then go to IDLE.
  - mem_rdata/if_data hold their value until that owner's next completion.
- Command registers (mem_addr, mem_value, mem_rd, mem_wr) hold from grant until the next grant. mem_rd/mem_wr clear on return to IDLE.
- Requester may keep req high after ready. This is taken as a new request, sampled in IDLE the cycle after RESP.
- Reset mid-operation: FSM to IDLE, command aborted, no ready pulse.

## Timing
- Reset values:
  - need_to_work, mem_rd, mem_wr, if_ready, mem_ready, busy = 0
  - mem_addr, mem_value, if_data, mem_rdata = 0
  - FSM = IDLE
- Grant at edge N; ISSUE (need_to_work high) from N+1.
- need_to_work drops the cycle after the start code is seen.
- Ready asserts 1 cycle after the done condition is sampled.
- Minimum latency from req to ready: 4 cycles plus controller time.
- Back-to-back: the next grant comes no earlier than 1 cycle after RESP.
- The controller holds IDLE for at least one clock-divider period, so the done condition is always observable in WAIT_DONE.

## Configuration
- MEM_ARB_IBUF_EN defined: one-entry fetch buffer (valid, tag, data).
  - IDLE with if_req, no mem_req, valid and tag==if_addr: go straight to RESP with buffered data. Hit latency is 2 cycles and no controller access is made.
  - The buffer fills on every IF completion except address UART_ADDR.
  - Any MEM store grant clears valid in the grant cycle.
  - Reset clears valid.
- Undefined: every fetch goes through the controller. No buffer logic is built.

## Structure
- Shared defines package holds:
  - UART_ADDR (16'hBF00)
  - the four controller start codes and its IDLE code
  - the FSM state encodings
  - owner enum (OWN_IF, OWN_MEM)
- Sub-module fetch_buf holds the MEM_ARB_IBUF_EN buffer: lookup, fill and invalidate ports. It is instantiated only under the macro.

## Test plan
- IF read 0x0010 with controller model returning 0x1234 → need_to_work until 8'h51, then if_ready one cycle with if_data=0x1234.
- mem_req store 0x0020←0xBEEF and if_req in the same cycle → MEM granted first, mem_wr=1, mem_value=0xBEEF. IF served afterwards and mem_ready precedes if_ready.
- Load from 0xBF00, model runs UART_READ1..3 before 8'h83 → arbiter stays in ISSUE through the receive sequence. mem_rdata is the queue value.
- Reset asserted during WAIT_DONE → all outputs 0 and busy=0 immediately. No ready pulse. A new request after reset completes normally.
- MEM_ARB_IBUF_EN on:
  - Two fetches of 0x0030 → second hits in 2 cycles, no need_to_work.
  - Store to 0x0040, then fetch 0x0030 → miss, controller accessed.
